data_mem_writeback: RTL and testbench
=====================================

# data_mem_writeback

Memory-side write-back sink for the L2 cache. Accepts a 512-bit dirty line plus its 26-bit line address from L2, serializes it into sixteen 32-bit word writes to an internal word-addressed RAM, then acknowledges with a level handshake. It is the write-direction counterpart of the instruction/data line-fill ROM and sits on the same L2–MEM boundary. A registered debug read port exposes RAM contents to the bench and to the line-fill side.

## Interface
Parameters:
- RAM_WIDTH, 32, word width; fixed at 32.
- RAM_DEPTH, 32'h3000, number of words in the internal RAM.
- START_ADDR, 32'h0, byte address mapped to RAM word 0; bits [5:2] give the word offset within the first line.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_L2_MEM  in  1  write-back request level from L2.
- addr_L2_MEM  in  26  line address (byte address [31:6]).
- write_data_L2_MEM  in  512  line data; word k is bits [32k+31:32k].
- ack_MEM_L2  out  1  line committed; held high until req_L2_MEM falls.
- busy  out  1  high in WRITE and ACK.
- oor_flag  out  1  sticky: at least one word was dropped as out of range.
- wb_count  out  32  number of completed lines; wraps modulo 2^32.
- dbg_addr  in  clogb2(RAM_DEPTH-1)  debug read word address.
- dbg_dout  out  32  debug read data, one-cycle latency.

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE: if req_L2_MEM=1, capture addr and data into line_addr_r/line_data_r, set cnt=0, go to WRITE. Otherwise hold.
- WRITE: each cycle handles word cnt. Word address = {line_addr_r - START_ADDR[31:6], cnt} - START_ADDR[5:2], computed 31 bits wide.
  - A word is invalid if the pre-subtraction value < START_ADDR[5:2] or the word address >= RAM_DEPTH.
  - Invalid word: write suppressed and oor_flag set. Valid word: RAM written.
  - At cnt=15: cnt wraps to 0, ack_MEM_L2 is set, wb_count increments, and the FSM goes to ACK.
- ACK: hold ack_MEM_L2=1. When req_L2_MEM=0, clear ack and return to IDLE. A new line is never captured in the same cycle that ACK exits.
- Input data and address are sampled only at the capture edge. L2 may change them afterwards.
- The debug port reads RAM at dbg_addr every cycle (read-first). A read and a write to the same address in the same cycle return the old word.
- The RAM has no reset. oor_flag clears only on rst.

## Timing
- Reset values: ack_MEM_L2=0, busy=0, oor_flag=0, wb_count=0, dbg_dout=0, state=IDLE, cnt=0.
- Capture edge E0. Word k is written at edge E(k+1), k=0..15. ack_MEM_L2 and the wb_count increment both become visible after E16, i.e. 16 cycles after capture.
- busy rises after E0 and falls after the edge at which ACK exits.
- Minimum request-to-request spacing is 18 cycles: capture, 16 writes, 1 ACK cycle with req low.
- If req_L2_MEM is low at E16, ACK is still entered and exits on the next edge. ack stays high for exactly one cycle.
- Reset mid-WRITE: returns to IDLE immediately, with no ack and no wb_count increment. Words already written remain in RAM.

## Configuration
- WB_WORD_MASK_EN defined:
  - Adds input word_en_L2_MEM [15:0], captured with the line.
  - A word with its enable bit at 0 is not written and does not set oor_flag, but still occupies its WRITE cycle, so latency is unchanged.
- WB_WORD_MASK_EN undefined: the port is absent and all 16 words are written, subject to range checks.

## Test plan
- Reset then idle: all outputs 0, dbg_dout=0 on an unwritten RAM (bench preloads 0). After 20 idle cycles, ack and busy remain 0.
- START_ADDR=0, write line addr 26'h1 with word k = 32'hA000_0000+k, then drop req after ack: dbg reads of words 16..31 return A000_0000..A000_000F; ack rises 16 cycles after capture; wb_count=1.
- Back-to-back: two lines (addr 0 and 2) with req re-asserted in the cycle after ack clears: second capture occurs after the ACK exit; wb_count=2; words 0..15 and 32..47 correct, words 16..31 untouched.
- RAM_DEPTH=32, write line addr 26'h1, then line addr 26'h2: the first line lands in words 16..31; the second writes nothing and sets oor_flag=1, which persists until rst.
- Assert rst at E8 of a write: words 0..6 hold new data, words 7..15 hold old data; ack never rises; wb_count=0.
- With WB_WORD_MASK_EN defined, word_en=16'h00FF: only words 0..7 are updated; ack latency is still 16 cycles.

Source files
------------

// File: rtl/data_mem_writeback_if.sv
// L2-to-memory write-back handshake bundle (line request, address, data, ack).
// WB_WORD_MASK_EN adds a per-word write enable carried with the line.
interface data_mem_writeback_if;
  logic         req_L2_MEM;
  logic [25:0]  addr_L2_MEM;
  logic [511:0] write_data_L2_MEM;
`ifdef WB_WORD_MASK_EN
  logic [15:0]  word_en_L2_MEM;
`endif
  logic         ack_MEM_L2;

`ifdef WB_WORD_MASK_EN
  modport master (output req_L2_MEM, addr_L2_MEM, write_data_L2_MEM, word_en_L2_MEM,
                  input  ack_MEM_L2);
  modport slave  (input  req_L2_MEM, addr_L2_MEM, write_data_L2_MEM, word_en_L2_MEM,
                  output ack_MEM_L2);
`else
  modport master (output req_L2_MEM, addr_L2_MEM, write_data_L2_MEM,
                  input  ack_MEM_L2);
  modport slave  (input  req_L2_MEM, addr_L2_MEM, write_data_L2_MEM,
                  output ack_MEM_L2);
`endif
endinterface

// File: rtl/data_mem_writeback.sv
// Write-back sink: captures a 512-bit L2 line, writes it as 16 words to internal RAM, then acks.
// Optional per-word write mask enabled by defining WB_WORD_MASK_EN.
module data_mem_writeback #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH  = 32'h3000,
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  data_mem_writeback_if.slave          wb,
  output logic                         busy,
  output logic                         oor_flag,
  output logic [31:0]                  wb_count,
  input  logic [$clog2(RAM_DEPTH)-1:0] dbg_addr,
  output logic [RAM_WIDTH-1:0]         dbg_dout
);
  localparam int          ADDR_W    = $clog2(RAM_DEPTH);
  localparam logic [25:0] BASE_LINE = START_ADDR[31:6];
  localparam logic [30:0] BASE_OFF  = {27'd0, START_ADDR[5:2]};
  localparam logic [31:0] DEPTH32   = 32'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic                 ack_r;
  logic [25:0]          line_addr_r;
  logic [511:0]         line_data_r;
  logic [30:0]          pre_addr;
  logic [30:0]          word_addr;
  logic                 word_sel;
  logic                 word_ok;
  logic                 word_we;
  logic [RAM_WIDTH-1:0] word_data;
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // A word is addressable only if it lies at or after START_ADDR and inside the RAM.
  function automatic logic in_range(input logic [30:0] pre, input logic [30:0] wa);
    return (pre >= BASE_OFF) && ({1'b0, wa} < DEPTH32);
  endfunction

`ifdef WB_WORD_MASK_EN
  logic [15:0] word_en_r;
  assign word_sel = word_en_r[cnt];
`else
  assign word_sel = 1'b1;
`endif

  assign pre_addr  = {1'b0, line_addr_r - BASE_LINE, cnt};
  assign word_addr = pre_addr - BASE_OFF;
  assign word_ok   = in_range(pre_addr, word_addr);
  assign word_we   = (state == WRITE) && word_sel && word_ok;
  assign word_data = line_data_r[{cnt, 5'd0} +: 32];
  assign wb.ack_MEM_L2 = ack_r;

  // Control FSM: IDLE -> WRITE (16 cycles) -> ACK (until req drops)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ack_r    <= 1'b0;
      busy     <= 1'b0;
      oor_flag <= 1'b0;
      wb_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (wb.req_L2_MEM) begin
            state <= WRITE;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end
        end
        WRITE: begin
          if (word_sel && !word_ok) oor_flag <= 1'b1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state    <= ACK;
            ack_r    <= 1'b1;
            wb_count <= wb_count + 32'd1;
          end
        end
        ACK: begin
          if (!wb.req_L2_MEM) begin
            state <= IDLE;
            ack_r <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line capture: address and data are sampled only on the accepting edge
  always_ff @(posedge clk) begin
    if (state == IDLE && wb.req_L2_MEM) begin
      line_addr_r <= wb.addr_L2_MEM;
      line_data_r <= wb.write_data_L2_MEM;
`ifdef WB_WORD_MASK_EN
      word_en_r   <= wb.word_en_L2_MEM;
`endif
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (word_we) mem[word_addr[ADDR_W-1:0]] <= word_data;
  end

  // Debug read port, read-first against a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_dout <= '0;
    else     dbg_dout <= mem[dbg_addr];
  end
endmodule

// File: tb/tb_data_mem_writeback.sv
// Randomized bench for data_mem_writeback: three instances with different depth/base share stimulus,
// each checked against an address-arithmetic reference model.
module tb_data_mem_writeback;
  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [25:0]  addr;
  logic [511:0] data;
  logic [15:0]  wen;

  int           DEP [3] = '{12288, 32, 64};
  logic [31:0]  SA  [3] = '{32'h0, 32'h0, 32'h48};

  logic [13:0]  dbg0;
  logic [4:0]   dbg1;
  logic [5:0]   dbg2;
  logic [31:0]  dout [3];
  logic [2:0]   busyv, oorv, ackv;
  logic [31:0]  wbc [3];

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  mmem [int];
  logic [2:0]   moor;
  logic [31:0]  mcount;

  data_mem_writeback_if bus0 ();
  data_mem_writeback_if bus1 ();
  data_mem_writeback_if bus2 ();

  assign bus0.req_L2_MEM = req;  assign bus0.addr_L2_MEM = addr;  assign bus0.write_data_L2_MEM = data;
  assign bus1.req_L2_MEM = req;  assign bus1.addr_L2_MEM = addr;  assign bus1.write_data_L2_MEM = data;
  assign bus2.req_L2_MEM = req;  assign bus2.addr_L2_MEM = addr;  assign bus2.write_data_L2_MEM = data;
`ifdef WB_WORD_MASK_EN
  assign bus0.word_en_L2_MEM = wen;
  assign bus1.word_en_L2_MEM = wen;
  assign bus2.word_en_L2_MEM = wen;
`endif
  assign ackv = {bus2.ack_MEM_L2, bus1.ack_MEM_L2, bus0.ack_MEM_L2};

  data_mem_writeback #(.RAM_WIDTH(32), .RAM_DEPTH(12288), .START_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .wb(bus0), .busy(busyv[0]), .oor_flag(oorv[0]),
    .wb_count(wbc[0]), .dbg_addr(dbg0), .dbg_dout(dout[0]));
  data_mem_writeback #(.RAM_WIDTH(32), .RAM_DEPTH(32), .START_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst), .wb(bus1), .busy(busyv[1]), .oor_flag(oorv[1]),
    .wb_count(wbc[1]), .dbg_addr(dbg1), .dbg_dout(dout[1]));
  data_mem_writeback #(.RAM_WIDTH(32), .RAM_DEPTH(64), .START_ADDR(32'h48)) dut2 (
    .clk(clk), .rst(rst), .wb(bus2), .busy(busyv[2]), .oor_flag(oorv[2]),
    .wb_count(wbc[2]), .dbg_addr(dbg2), .dbg_dout(dout[2]));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: word k of the line goes to byte address {line,k,2'b00} minus START_ADDR, if it fits.
  task automatic model_line(input logic [25:0] a, input logic [511:0] d, input logic [15:0] en,
                            input int upto);
    for (int dd = 0; dd < 3; dd++) begin
      for (int k = 0; k < upto; k++) begin
        logic [25:0] rel;
        longint      pre, wa;
        if (en[k]) begin
          rel = a - SA[dd][31:6];
          pre = longint'(rel) * 16 + k;
          wa  = pre - longint'(SA[dd][5:2]);
          if (pre < longint'(SA[dd][5:2]) || wa >= longint'(DEP[dd])) moor[dd] = 1'b1;
          else mmem[dd * 65536 + int'(wa)] = d[32*k +: 32];
        end
      end
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_status(input string tag);
    for (int dd = 0; dd < 3; dd++) begin
      check($sformatf("%s.oor%0d", tag, dd), 64'(oorv[dd]), 64'(moor[dd]));
      check($sformatf("%s.wbc%0d", tag, dd), 64'(wbc[dd]), 64'(mcount));
    end
  endtask

  task automatic send_line(input logic [25:0] a, input logic [511:0] d, input logic [15:0] en,
                           input bit early_drop);
    logic [15:0] eff_en;
    int          lat;
`ifdef WB_WORD_MASK_EN
    eff_en = en;
`else
    eff_en = 16'hFFFF;
`endif
    @(negedge clk);
    req = 1'b1; addr = a; data = d; wen = en;
    @(posedge clk);
    model_line(a, d, eff_en, 16);
    @(negedge clk);
    check("busy_after_capture", 64'(busyv), 64'd7);
    addr = 26'($urandom); data = rand_line(); wen = 16'($urandom);
    if (early_drop) req = 1'b0;
    lat = 0;
    while (ackv[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ack_latency", 64'(lat), 64'd16);
    check("ack_all", 64'(ackv), 64'd7);
    mcount = mcount + 32'd1;
    check_status("line");
    req = 1'b0;
    @(negedge clk);
    check("ack_cleared", 64'(ackv), 64'd0);
    check("busy_cleared", 64'(busyv), 64'd0);
  endtask

  task automatic check_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      dbg0 = a[13:0]; dbg1 = a[4:0]; dbg2 = a[5:0];
      @(negedge clk);
      for (int dd = 0; dd < 3; dd++)
        if (a < DEP[dd] && mmem.exists(dd * 65536 + a))
          check($sformatf("mem%0d[%0d]", dd, a), 64'(dout[dd]), 64'(mmem[dd * 65536 + a]));
    end
  endtask

  initial begin
    logic [511:0] l;
    rst = 1'b1; req = 1'b0; addr = '0; data = '0; wen = 16'hFFFF;
    dbg0 = '0; dbg1 = '0; dbg2 = '0; moor = '0; mcount = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 64'(ackv), 64'd0);
    check("rst_busy", 64'(busyv), 64'd0);
    check("rst_dout", 64'(dout[0]), 64'd0);
    check_status("rst");
    repeat (20) @(negedge clk);
    check("idle_ack", 64'(ackv), 64'd0);
    check("idle_busy", 64'(busyv), 64'd0);

    // Known pattern to line 1
    for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'hA000_0000 + 32'(k);
    send_line(26'h1, l, 16'hFFFF, 1'b0);
    check_mem(0, 63);

    // Back-to-back lines 0 and 2; line 2 overflows the 32-word instance
    send_line(26'h0, rand_line(), 16'hFFFF, 1'b0);
    send_line(26'h2, rand_line(), 16'hFFFF, 1'b0);
    check("oor_small", 64'(oorv[1]), 64'd1);
    check_mem(0, 63);

`ifdef WB_WORD_MASK_EN
    send_line(26'h0, rand_line(), 16'h00FF, 1'b0);
    check_mem(0, 63);
`endif

    // req already low when the last word is written
    send_line(26'h3, rand_line(), 16'hFFFF, 1'b1);
    check_status("early_drop");

    // Reset mid-write after words 0..6 have been written
    @(negedge clk);
    l = rand_line();
    req = 1'b1; addr = 26'h0; data = l; wen = 16'hFFFF;
    @(posedge clk);
    model_line(26'h0, l, 16'hFFFF, 7);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    moor = '0; mcount = 32'd0;
    req = 1'b0;
    #1;
    check("midrst_busy", 64'(busyv), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ackv !== 3'd0) check("midrst_no_ack", 64'(ackv), 64'd0);
    end
    check("midrst_ack_end", 64'(ackv), 64'd0);
    check_status("midrst");
    check_mem(0, 63);

    // Randomized lines, a few past the end of the large RAM
    for (int i = 0; i < 40; i++)
      send_line(26'($urandom_range(0, 800)), rand_line(), 16'($urandom), 1'($urandom));
    check_mem(0, 12287);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
